// File: rtl/btc_status_gpio_tx.sv
// ----------------------------------------------------------------------------
// btc_status_gpio_tx
//
// Publishes 16-bit firmware/miner status codes (e.g. 16'hFEED start,
// 16'hDEAD done) on the user GPIO checkpoint field mprj_io[31:16]. Codes are
// queued in a small FIFO. Each popped code is held on the pads for
// HOLD_CYCLES cycles so that a slow external monitor can sample it.
//
// Parameters
//   DEPTH        code FIFO entries, power of two, 2..16
//   HOLD_CYCLES  minimum cycles each code is driven, 1..65535
//
// Ports
//   wb_clk_i      in   sole clock, all state on rising edge
//   wb_rst_i      in   asynchronous, active-high reset
//   en_i          in   enables popping new codes and driving the pads
//   code_i        in   status code to publish (16 bits)
//   code_valid_i  in   code_i is valid
//   code_ready_o  out  FIFO can accept a code
//   io_out        out  pad data, maps to mprj_io[31:16]
//   io_oeb        out  pad output-enable bar, 0 = drive
//   io_strobe_o   out  (BTC_STATUS_STROBE_EN only) toggles on every code load,
//                      intended for mprj_io[32]
//   io_strobe_oeb_o out (BTC_STATUS_STROBE_EN only) enable-bar for the strobe
//                      pad, follows io_oeb[0]
//   busy_o        out  a hold is in progress or the FIFO is non-empty
//
// Optional feature macro: BTC_STATUS_STROBE_EN
// ----------------------------------------------------------------------------
module btc_status_gpio_tx #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        en_i,
    input  logic [15:0] code_i,
    input  logic        code_valid_i,
    output logic        code_ready_o,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb,
`ifdef BTC_STATUS_STROBE_EN
    output logic        io_strobe_o,
    output logic        io_strobe_oeb_o,
`endif
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [15:0]   HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     io_out_q, io_out_d;
    logic [15:0]     io_oeb_q, io_oeb_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     mem_q [DEPTH];

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    // FIFO status is taken from registered occupancy only, so a pop in the
    // same cycle never opens room for a push while full.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = code_valid_i && !full;

    // ---------------- state register ----------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            io_out_q <= '0;
            io_oeb_q <= 16'hFFFF;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            io_out_q <= io_out_d;
            io_oeb_q <= io_oeb_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reset empties the FIFO through its pointers
    // and occupancy, so stale entries are never read.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= code_i;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en_i && !empty) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // At the end of a hold, chain straight into the next code
                // when possible; otherwise fall back to IDLE.
                if ((cnt_q == '0) && !(en_i && !empty)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        pop = 1'b0;
        case (state_q)
            S_IDLE:  pop = en_i && !empty;
            S_HOLD:  pop = (cnt_q == '0) && en_i && !empty;
            default: pop = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        io_out_d = io_out_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        io_oeb_d = en_i ? 16'h0000 : 16'hFFFF;

        if (pop) begin
            io_out_d = mem_q[rd_ptr_q];
            cnt_d    = HOLD_RELOAD;
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else if ((state_q == S_HOLD) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 16'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        // Simultaneous push and pop leaves occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef BTC_STATUS_STROBE_EN
    logic strobe_q, strobe_d;

    // Toggles with every load so repeated identical codes remain visible.
    always_comb begin
        strobe_d = strobe_q ^ pop;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign io_strobe_o     = strobe_q;
    assign io_strobe_oeb_o = io_oeb_q[0];
`endif

    assign code_ready_o = !full;
    assign io_out       = io_out_q;
    assign io_oeb       = io_oeb_q;
    assign busy_o       = (state_q == S_HOLD) || !empty;

endmodule

// File: tb/tb_btc_status_gpio_tx.sv
// ----------------------------------------------------------------------------
// tb_btc_status_gpio_tx
//
// Scoreboard bench for btc_status_gpio_tx (DEPTH=4, HOLD_CYCLES=64).
// Each accepted push queues its expected code; a monitor watches io_out and,
// whenever a new code appears, pops the queue, compares the code and, where
// the code was chained back-to-back, checks the previous code's hold length.
// ----------------------------------------------------------------------------
module tb_btc_status_gpio_tx;

    localparam int DEPTH       = 4;
    localparam int HOLD_CYCLES = 64;

    logic        clk;
    logic        rst;
    logic        en_i;
    logic [15:0] code_i;
    logic        code_valid_i;
    logic        code_ready_o;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic        busy_o;
`ifdef BTC_STATUS_STROBE_EN
    logic        io_strobe_o;
    logic        io_strobe_oeb_o;
`endif

    typedef struct {
        logic [15:0] code;
        bit          exact;   // previous code must have been held exactly HOLD_CYCLES
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    btc_status_gpio_tx #(
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .en_i        (en_i),
        .code_i      (code_i),
        .code_valid_i(code_valid_i),
        .code_ready_o(code_ready_o),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
`ifdef BTC_STATUS_STROBE_EN
        .io_strobe_o    (io_strobe_o),
        .io_strobe_oeb_o(io_strobe_oeb_o),
`endif
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Drives one code for one edge; the caller guarantees code_ready_o is high.
    task automatic push(input logic [15:0] c, input bit exact);
        exp_t e;
        e.code  = c;
        e.exact = exact;
        exp_q.push_back(e);
        code_i       = c;
        code_valid_i = 1'b1;
        tick();
        code_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy_o) break;
            tick();
        end
        check(name, {31'd0, busy_o}, 32'd0);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    logic [15:0] prev_out;
    int          run_len;

    always @(negedge clk) begin
        if (rst) begin
            prev_out = io_out;
            run_len  = 0;
        end else if (io_out !== prev_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_code actual=%h required=none", io_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("code_order", {16'd0, io_out}, {16'd0, e.code});
                if (e.exact) begin
                    check("hold_length", run_len, HOLD_CYCLES);
                end
            end
            prev_out = io_out;
            run_len  = 1;
        end else begin
            run_len++;
        end
    end

    initial begin
        rst          = 1'b0;
        en_i         = 1'b0;
        code_i       = '0;
        code_valid_i = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_io_out", {16'd0, io_out}, 32'h0000_0000);
        check("rst_io_oeb", {16'd0, io_oeb}, 32'h0000_FFFF);
        check("rst_ready",  {31'd0, code_ready_o}, 32'd1);
        check("rst_busy",   {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Single code: latency, hold length, retention in IDLE
        en_i = 1'b1;
        repeat (8) tick();
        push(16'hFEED, 1'b0);
        check("feed_not_early", {16'd0, io_out}, 32'h0000_0000);
        tick();
        check("feed_latency", {16'd0, io_out}, 32'h0000_FEED);
        check("oeb_enabled",  {16'd0, io_oeb}, 32'h0000_0000);
        repeat (63) tick();
        check("busy_last_hold", {31'd0, busy_o}, 32'd1);
        tick();
        check("busy_drop", {31'd0, busy_o}, 32'd0);
        repeat (120) tick();
        check("feed_retained", {16'd0, io_out}, 32'h0000_FEED);

        // Back-to-back codes: chained with no gap
        apply_reset();
        check("rst2_io_out", {16'd0, io_out}, 32'h0000_0000);
        push(16'hFEED, 1'b0);
        push(16'h1234, 1'b1);
        push(16'hDEAD, 1'b1);
        wait_idle("b2b_idle", 400);
        repeat (10) tick();
        check("dead_retained", {16'd0, io_out}, 32'h0000_DEAD);

        // FIFO full with pads disabled, then release
        en_i = 1'b0;
        apply_reset();
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b1);
        push(16'h3333, 1'b1);
        push(16'h4444, 1'b1);
        check("full_ready_low", {31'd0, code_ready_o}, 32'd0);
        check("dis_oeb",        {16'd0, io_oeb}, 32'h0000_FFFF);
        check("dis_busy",       {31'd0, busy_o}, 32'd1);
        begin
            exp_t e;
            e.code  = 16'h5555;
            e.exact = 1'b1;
            exp_q.push_back(e);
        end
        code_i       = 16'h5555;
        code_valid_i = 1'b1;
        repeat (3) tick();
        check("fifth_stalled", {31'd0, code_ready_o}, 32'd0);
        check("dis_no_pop",    {16'd0, io_out}, 32'h0000_0000);
        en_i = 1'b1;
        #1;
        check("oeb_registered", {16'd0, io_oeb}, 32'h0000_FFFF);
        tick();
        check("first_pop",       {16'd0, io_out}, 32'h0000_1111);
        check("oeb_after_en",    {16'd0, io_oeb}, 32'h0000_0000);
        check("ready_after_pop", {31'd0, code_ready_o}, 32'd1);
        tick();
        code_valid_i = 1'b0;
        check("fifth_accepted_full", {31'd0, code_ready_o}, 32'd0);
        wait_idle("full_idle", 800);
        check("last_retained", {16'd0, io_out}, 32'h0000_5555);

        // Asynchronous reset mid-hold with codes queued
        apply_reset();
        push(16'hA001, 1'b0);
        push(16'hA002, 1'b0);
        push(16'hA003, 1'b0);
        push(16'hA004, 1'b0);
        repeat (20) tick();
        check("pre_rst_code", {16'd0, io_out}, 32'h0000_A001);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_io_out", {16'd0, io_out}, 32'h0000_0000);
        check("async_io_oeb", {16'd0, io_oeb}, 32'h0000_FFFF);
        check("async_ready",  {31'd0, code_ready_o}, 32'd1);
        check("async_busy",   {31'd0, busy_o}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (300) tick();
        check("flushed_io_out", {16'd0, io_out}, 32'h0000_0000);
        check("flushed_busy",   {31'd0, busy_o}, 32'd0);
        check("flushed_oeb",    {16'd0, io_oeb}, 32'h0000_0000);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always ends by itself.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
